lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Load/store sequencer between the execute stage and the 1 KiB data memory / GPO peripheral bus.
- Accepts one RV32 load or store per request, checks alignment and range, and drives address, byte-lane enables and lane-aligned write data to memory.
- Extracts, shifts and sign/zero-extends load data and returns a one-cycle response pulse.
- Holds the pipeline via ready while a transaction is in flight.

Parameters:
ADDR_BITS, 10, width of physical memory address; accesses with any set bit in addr[31:ADDR_BITS] are out of range.
DATA_BITS, 32, data word width; fixed at 32, any other value is unsupported.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present; accepted when req_valid && ready.
req_write  input  1  1 = store, 0 = load.
req_funct3  input  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 for stores.
req_addr  input  32  effective byte address.
req_wdata  input  32  store data, value in low bits.
ready  output  1  1 only in IDLE.
mem_select  output  1  memory access strobe.
mem_write  output  1  memory write enable.
mem_addr  output  ADDR_BITS  byte address to memory.
mem_width  output  4  byte-lane enables; bit k = data bits [8k+7:8k] = address offset k.
mem_wdata  output  32  lane-aligned write data.
mem_rdata  input  32  memory read data, valid the cycle after mem_select; lane k = offset k.
resp_valid  output  1  one-cycle completion pulse.
resp_rdata  output  32  extended load result; 0 for stores and errors.
resp_err  output  1  qualifies resp_valid: misaligned, out of range, or illegal funct3.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. ready=1; mem_select, mem_write, resp_valid, resp_err = 0; mem_addr, mem_width, mem_wdata, resp_rdata = 0. Asserting reset mid-transaction aborts it immediately; no write is issued afterwards.
- All outputs are registered, except ready, which is decoded from state.
- States: IDLE, ISSUE, WAIT, RESP.

IDLE:
- On acceptance, decode the request.
- err = illegal funct3 (011, 110, 111; or 1xx for a store), OR halfword with addr[0]=1, OR word with addr[1:0]!=0, OR addr[31:ADDR_BITS]!=0.
- If err: go to RESP with resp_err=1 and resp_rdata=0. No memory access.
- Otherwise:
  - Register mem_addr = addr[ADDR_BITS-1:0] and mem_select=1.
  - mem_width: B = 1<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111; for loads mem_width is still driven.
  - mem_wdata = req_wdata shifted left by 8*addr[1:0] (B and H replicate nothing; unused lanes are 0).
  - mem_write = req_write.
  - Save funct3 and addr[1:0]; go to ISSUE.

ISSUE:
- Memory samples the bus at the end of this cycle.
- Next edge: mem_select=0, mem_write=0.
- Store → RESP with resp_valid=1, resp_err=0, resp_rdata=0.
- Load → WAIT.

WAIT:
- mem_rdata is valid this cycle.
- Shift right by 8*saved offset.
- Extend: B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- Register the result into resp_rdata; go to RESP with resp_valid=1.

RESP:
- resp_valid is high for exactly this cycle; ready=0.
- Next edge: resp_valid=0, resp_err=0, back to IDLE.
- resp_rdata holds its value until the next response.

Latency:
- Load: accept edge N; mem strobe in cycle N+1; resp_valid in cycle N+3.
- Store: resp_valid in cycle N+2.
- Error: resp_valid in cycle N+1.
- Back-to-back: the next request can be accepted the cycle after RESP. Throughput is 1 load per 4 cycles and 1 store per 3.

Boundary cases:
- req_valid while ready=0 is ignored; the requester holds it.
- Stores to the GPO address 0x050 pass through unchanged; decode is the peripheral's job.
- Address 0x3FF with a byte access is legal.
- Address 0x3FE with a word access is misaligned.

Test Plan:
1. Reset held mid-load (in WAIT), released → ready=1, resp_valid never pulses, mem_select=0, and the next request runs normally.
2. SW addr=0x008 wdata=0xDEADBEEF, then LW 0x008 → store: mem_width=1111, mem_wdata=0xDEADBEEF, resp in 2 cycles. Load: resp_rdata=0xDEADBEEF, resp_valid at N+3.
3. SB addr=0x00B wdata=0x000000A5 → mem_width=1000, mem_wdata=0xA5000000. LB 0x00B → 0xFFFFFFA5; LBU 0x00B → 0x000000A5.
4. SH addr=0x012 wdata=0x8001 → mem_width=1100, mem_wdata=0x80010000. LH 0x012 → 0xFFFF8001; LHU → 0x00008001.
5. LW addr=0x006, LH addr=0x005, SB addr=0x400 → each gives resp_err=1 and resp_valid one cycle after accept; mem_select stays 0.
6. SB addr=0x050 wdata=0x3C, then immediately another request held valid → mem_addr=0x050, mem_write pulse of one cycle, mem_width=0001. The second request is accepted only once ready returns, and no request is lost.

Source files
------------

// File: rtl/lsu_mem_stage_if.sv
// rtl/lsu_mem_stage_if.sv - request, memory bus and response signals of the load/store stage
// slave is the LSU view; master is the execute stage plus data memory side.
interface lsu_mem_stage_if #(
   parameter int ADDR_BITS = 10
);
   logic                 req_valid;
   logic                 req_write;
   logic [2:0]           req_funct3;
   logic [31:0]          req_addr;
   logic [31:0]          req_wdata;
   logic                 ready;
   logic                 mem_select;
   logic                 mem_write;
   logic [ADDR_BITS-1:0] mem_addr;
   logic [3:0]           mem_width;
   logic [31:0]          mem_wdata;
   logic [31:0]          mem_rdata;
   logic                 resp_valid;
   logic [31:0]          resp_rdata;
   logic                 resp_err;

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
      output ready, mem_select, mem_write, mem_addr, mem_width, mem_wdata,
      output resp_valid, resp_rdata, resp_err
   );

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
      input  ready, mem_select, mem_write, mem_addr, mem_width, mem_wdata,
      input  resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - RV32 load/store sequencer to the data memory / GPO bus
// IDLE accepts and decodes, ISSUE strobes memory, WAIT extracts load data, RESP pulses the response.
module lsu_mem_stage #(
   parameter int ADDR_BITS = 10,
   parameter int DATA_BITS = 32
) (
   input logic             clk_i,
   input logic             rst_n_i,
   lsu_mem_stage_if.slave  lsu_io
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   logic [1:0]           state_q, state_d;
   logic                 mem_select_q, mem_select_d;
   logic                 mem_write_q, mem_write_d;
   logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
   logic [3:0]           mem_width_q, mem_width_d;
   logic [31:0]          mem_wdata_q, mem_wdata_d;
   logic                 resp_valid_q, resp_valid_d;
   logic [31:0]          resp_rdata_q, resp_rdata_d;
   logic                 resp_err_q, resp_err_d;
   logic [2:0]           funct3_q, funct3_d;
   logic [1:0]           off_q, off_d;

   logic [1:0]           req_off;
   logic                 f3_illegal, misaligned, out_of_range, req_err;
   logic [3:0]           lane_mask;
   logic [31:0]          lane_wdata_raw;
   logic [31:0]          lane_wdata;
   logic [DATA_BITS-1:0] rdata_shifted;
   logic [DATA_BITS-1:0] load_result;

   assign req_off = lsu_io.req_addr[1:0];

   // Unsigned load encodings are meaningless for stores, so they are flagged too.
   always_comb begin
      f3_illegal = 1'b1;
      case (lsu_io.req_funct3)
         3'b000, 3'b001, 3'b010: f3_illegal = 1'b0;
         3'b100, 3'b101:         f3_illegal = lsu_io.req_write;
         default:                f3_illegal = 1'b1;
      endcase
   end

   assign misaligned   = ((lsu_io.req_funct3[1:0] == 2'b01) && req_off[0]) ||
                         ((lsu_io.req_funct3[1:0] == 2'b10) && (req_off != 2'b00));
   assign out_of_range = |lsu_io.req_addr[31:ADDR_BITS];
   assign req_err      = f3_illegal || misaligned || out_of_range;

   always_comb begin
      lane_mask      = 4'b1111;
      lane_wdata_raw = lsu_io.req_wdata;
      case (lsu_io.req_funct3[1:0])
         2'b00: begin
            lane_mask      = 4'b0001 << req_off;
            lane_wdata_raw = {24'd0, lsu_io.req_wdata[7:0]};
         end
         2'b01: begin
            lane_mask      = 4'b0011 << req_off;
            lane_wdata_raw = {16'd0, lsu_io.req_wdata[15:0]};
         end
         default: begin
            lane_mask      = 4'b1111;
            lane_wdata_raw = lsu_io.req_wdata;
         end
      endcase
   end

   assign lane_wdata    = lane_wdata_raw << {req_off, 3'b000};
   assign rdata_shifted = lsu_io.mem_rdata >> {off_q, 3'b000};

   always_comb begin
      case (funct3_q)
         3'b000:  load_result = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
         3'b001:  load_result = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
         3'b100:  load_result = {24'd0, rdata_shifted[7:0]};
         3'b101:  load_result = {16'd0, rdata_shifted[15:0]};
         default: load_result = rdata_shifted;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      mem_select_d = mem_select_q;
      mem_write_d  = mem_write_q;
      mem_addr_d   = mem_addr_q;
      mem_width_d  = mem_width_q;
      mem_wdata_d  = mem_wdata_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      funct3_d     = funct3_q;
      off_d        = off_q;
      case (state_q)
         IDLE: begin
            if (lsu_io.req_valid) begin
               if (req_err) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'd0;
               end else begin
                  state_d      = ISSUE;
                  mem_select_d = 1'b1;
                  mem_write_d  = lsu_io.req_write;
                  mem_addr_d   = lsu_io.req_addr[ADDR_BITS-1:0];
                  mem_width_d  = lane_mask;
                  mem_wdata_d  = lane_wdata;
                  funct3_d     = lsu_io.req_funct3;
                  off_d        = req_off;
               end
            end
         end
         ISSUE: begin
            // mem_write_q still carries the request direction during this cycle.
            mem_select_d = 1'b0;
            mem_write_d  = 1'b0;
            if (mem_write_q) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_rdata_d = 32'd0;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = load_result;
         end
         default: begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
            resp_err_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         mem_select_q <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_width_q  <= 4'd0;
         mem_wdata_q  <= 32'd0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
         funct3_q     <= 3'd0;
         off_q        <= 2'd0;
      end else begin
         state_q      <= state_d;
         mem_select_q <= mem_select_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_width_q  <= mem_width_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         funct3_q     <= funct3_d;
         off_q        <= off_d;
      end
   end

   assign lsu_io.ready      = (state_q == IDLE);
   assign lsu_io.mem_select = mem_select_q;
   assign lsu_io.mem_write  = mem_write_q;
   assign lsu_io.mem_addr   = mem_addr_q;
   assign lsu_io.mem_width  = mem_width_q;
   assign lsu_io.mem_wdata  = mem_wdata_q;
   assign lsu_io.resp_valid = resp_valid_q;
   assign lsu_io.resp_rdata = resp_rdata_q;
   assign lsu_io.resp_err   = resp_err_q;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - self-checking bench for lsu_mem_stage
// A byte-array reference memory predicts every response; a word-array bus model serves the DUT.
module tb_lsu_mem_stage;
   logic clk_i;
   logic rst_n_i;
   int   checks;
   int   errors;

   lsu_mem_stage_if #(.ADDR_BITS(10)) bus ();

   lsu_mem_stage #(.ADDR_BITS(10), .DATA_BITS(32)) dut (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .lsu_io  (bus.slave)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic [31:0] mem_words [256];
   logic [7:0]  ref_mem [1024];

   // Word-wide memory: samples the bus at the end of the strobe cycle, read data registered.
   always @(posedge clk_i) begin
      if (bus.mem_select) begin
         if (bus.mem_write) begin
            for (int k = 0; k < 4; k++)
               if (bus.mem_width[k]) mem_words[bus.mem_addr[9:2]][8*k +: 8] <= bus.mem_wdata[8*k +: 8];
         end
         bus.mem_rdata <= mem_words[bus.mem_addr[9:2]];
      end
   end

   task automatic model(input bit wr, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wd,
                        output bit e, output bit [3:0] w, output bit [31:0] wdat,
                        output bit [31:0] rd, output int lat);
      int size;
      bit legal_f3;
      bit [63:0] val;
      size     = 1 << f3[1:0];
      legal_f3 = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      e        = !legal_f3 || (addr % size != 0) || (addr >= 1024);
      w        = 4'd0;
      wdat     = 32'd0;
      rd       = 32'd0;
      if (e) begin
         lat = 1;
      end else begin
         w    = 4'(((1 << size) - 1) << (addr % 4));
         val  = (size == 4) ? 64'(wd) : 64'(wd) % (64'd1 << (8 * size));
         wdat = 32'(val << (8 * (addr % 4)));
         if (wr) begin
            lat = 2;
            for (int i = 0; i < size; i++) ref_mem[addr + i] = wd[8*i +: 8];
         end else begin
            lat = 3;
            val = 64'd0;
            for (int i = 0; i < size; i++) val = val + (64'(ref_mem[addr + i]) << (8 * i));
            if (!f3[2] && size < 4 && val[8*size - 1]) val = val + (64'hFFFF_FFFF << (8 * size));
            rd = 32'(val);
         end
      end
   endtask

   task automatic do_req(input bit wr, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wd,
                         output bit g_err, output bit [31:0] g_rd, output int g_lat,
                         output int sel_cyc, output int wr_cyc, output bit [9:0] o_addr,
                         output bit [3:0] o_width, output bit [31:0] o_wdata, output int waited);
      @(negedge clk_i);
      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
      waited = 0;
      while (!bus.ready && waited < 20) begin
         @(negedge clk_i);
         waited++;
      end
      @(posedge clk_i);
      #1;
      bus.req_valid = 1'b0;
      o_addr  = bus.mem_addr;
      o_width = bus.mem_width;
      o_wdata = bus.mem_wdata;
      sel_cyc = int'(bus.mem_select);
      wr_cyc  = int'(bus.mem_select && bus.mem_write);
      g_lat   = 1;
      while (!bus.resp_valid && g_lat < 10) begin
         @(posedge clk_i);
         #1;
         g_lat++;
         sel_cyc += int'(bus.mem_select);
         wr_cyc  += int'(bus.mem_select && bus.mem_write);
      end
      g_err = bus.resp_err;
      g_rd  = bus.resp_rdata;
   endtask

   bit        g_err, e_err;
   bit [31:0] g_rd, e_rd, o_wdata, e_wdata;
   bit [3:0]  o_width, e_width;
   bit [9:0]  o_addr;
   int        g_lat, e_lat, sel_cyc, wr_cyc, waited;

   task automatic test_reset;
      rst_n_i = 1'b0;
      repeat (2) @(negedge clk_i);
      checks++;
      if ({bus.ready, bus.mem_select, bus.mem_write, bus.resp_valid, bus.resp_err} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 10000",
                  {bus.ready, bus.mem_select, bus.mem_write, bus.resp_valid, bus.resp_err});
      end
      checks++;
      if ({bus.mem_addr, bus.mem_width, bus.mem_wdata, bus.resp_rdata} !== 78'd0) begin
         errors++;
         $display("FAIL reset_data got addr %h width %b wdata %h rdata %h want all 0",
                  bus.mem_addr, bus.mem_width, bus.mem_wdata, bus.resp_rdata);
      end
      rst_n_i = 1'b1;
   endtask

   task automatic test_reset_mid_load;
      int pulses;
      @(negedge clk_i);
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b0;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h20;
      @(posedge clk_i);
      #1;
      bus.req_valid = 1'b0;
      @(posedge clk_i);
      #2;
      rst_n_i = 1'b0;
      #1;
      checks++;
      if ({bus.ready, bus.mem_select, bus.resp_valid} !== 3'b100) begin
         errors++;
         $display("FAIL mid_load_reset got ready/sel/resp %b want 100",
                  {bus.ready, bus.mem_select, bus.resp_valid});
      end
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b1;
      pulses = 0;
      repeat (6) begin
         @(posedge clk_i);
         #1;
         pulses += int'(bus.resp_valid) + int'(bus.mem_select);
      end
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("FAIL mid_load_quiet got %0d strobes/pulses want 0", pulses);
      end
      model(1'b0, 3'b010, 32'h20, 32'd0, e_err, e_width, e_wdata, e_rd, e_lat);
      do_req(1'b0, 3'b010, 32'h20, 32'd0, g_err, g_rd, g_lat, sel_cyc, wr_cyc, o_addr, o_width, o_wdata, waited);
      checks++;
      if (g_rd !== e_rd || g_lat !== 3 || g_err !== 1'b0) begin
         errors++;
         $display("FAIL after_reset_load got rdata %h lat %0d err %b want %h 3 0", g_rd, g_lat, g_err, e_rd);
      end
   endtask

   task automatic test_store_load_word;
      model(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, e_err, e_width, e_wdata, e_rd, e_lat);
      do_req(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, g_err, g_rd, g_lat, sel_cyc, wr_cyc, o_addr, o_width, o_wdata, waited);
      checks++;
      if (o_width !== 4'b1111 || o_wdata !== 32'hDEADBEEF || o_addr !== 10'h8 || g_lat !== 2 || wr_cyc !== 1) begin
         errors++;
         $display("FAIL sw got width %b wdata %h addr %h lat %0d wr %0d want 1111 deadbeef 008 2 1",
                  o_width, o_wdata, o_addr, g_lat, wr_cyc);
      end
      @(posedge clk_i);
      #1;
      checks++;
      if (bus.resp_valid !== 1'b0 || bus.ready !== 1'b1) begin
         errors++;
         $display("FAIL resp_one_cycle got resp_valid %b ready %b want 0 1", bus.resp_valid, bus.ready);
      end
      model(1'b0, 3'b010, 32'h8, 32'd0, e_err, e_width, e_wdata, e_rd, e_lat);
      do_req(1'b0, 3'b010, 32'h8, 32'd0, g_err, g_rd, g_lat, sel_cyc, wr_cyc, o_addr, o_width, o_wdata, waited);
      checks++;
      if (g_rd !== 32'hDEADBEEF || g_lat !== 3 || sel_cyc !== 1 || wr_cyc !== 0) begin
         errors++;
         $display("FAIL lw got rdata %h lat %0d sel %0d wr %0d want deadbeef 3 1 0", g_rd, g_lat, sel_cyc, wr_cyc);
      end
   endtask

   task automatic test_sub_word;
      bit        wr_t [7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      bit [2:0]  f3_t [7]  = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b001, 3'b101, 3'b100};
      bit [31:0] ad_t [7]  = '{32'h0B, 32'h0B, 32'h0B, 32'h12, 32'h12, 32'h12, 32'h3FF};
      bit [31:0] wd_t [7]  = '{32'hA5, 32'h0, 32'h0, 32'h8001, 32'h0, 32'h0, 32'h0};
      bit [3:0]  wid_t [7] = '{4'b1000, 4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1100, 4'b1000};
      bit [31:0] res_t [7] = '{32'hA5000000, 32'hFFFFFFA5, 32'h000000A5, 32'h80010000,
                               32'hFFFF8001, 32'h00008001, 32'h0};
      for (int i = 0; i < 7; i++) begin
         model(wr_t[i], f3_t[i], ad_t[i], wd_t[i], e_err, e_width, e_wdata, e_rd, e_lat);
         do_req(wr_t[i], f3_t[i], ad_t[i], wd_t[i], g_err, g_rd, g_lat, sel_cyc, wr_cyc, o_addr, o_width, o_wdata, waited);
         checks++;
         if (o_width !== wid_t[i] || g_err !== 1'b0 || (wr_t[i] && o_wdata !== res_t[i]) ||
             (!wr_t[i] && i < 6 && g_rd !== res_t[i]) || (i == 6 && g_rd !== e_rd)) begin
            errors++;
            $display("FAIL sub_word[%0d] got width %b wdata %h rdata %h err %b want width %b value %h",
                     i, o_width, o_wdata, g_rd, g_err, wid_t[i], (i == 6) ? e_rd : res_t[i]);
         end
      end
   endtask

   task automatic test_errors;
      bit        wr_t [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      bit [2:0]  f3_t [5] = '{3'b010, 3'b001, 3'b000, 3'b010, 3'b100};
      bit [31:0] ad_t [5] = '{32'h6, 32'h5, 32'h400, 32'h3FE, 32'h10};
      for (int i = 0; i < 5; i++) begin
         model(wr_t[i], f3_t[i], ad_t[i], 32'h12345678, e_err, e_width, e_wdata, e_rd, e_lat);
         do_req(wr_t[i], f3_t[i], ad_t[i], 32'h12345678, g_err, g_rd, g_lat, sel_cyc, wr_cyc, o_addr, o_width, o_wdata, waited);
         checks++;
         if (g_err !== 1'b1 || g_lat !== 1 || sel_cyc !== 0 || g_rd !== 32'd0) begin
            errors++;
            $display("FAIL error[%0d] got err %b lat %0d sel %0d rdata %h want 1 1 0 0",
                     i, g_err, g_lat, sel_cyc, g_rd);
         end
      end
   endtask

   task automatic test_back_to_back;
      model(1'b1, 3'b000, 32'h50, 32'h3C, e_err, e_width, e_wdata, e_rd, e_lat);
      do_req(1'b1, 3'b000, 32'h50, 32'h3C, g_err, g_rd, g_lat, sel_cyc, wr_cyc, o_addr, o_width, o_wdata, waited);
      checks++;
      if (o_addr !== 10'h050 || wr_cyc !== 1 || o_width !== 4'b0001 || o_wdata !== 32'h3C || g_lat !== 2) begin
         errors++;
         $display("FAIL gpo_store got addr %h wr %0d width %b wdata %h lat %0d want 050 1 0001 0000003c 2",
                  o_addr, wr_cyc, o_width, o_wdata, g_lat);
      end
      model(1'b0, 3'b100, 32'h50, 32'd0, e_err, e_width, e_wdata, e_rd, e_lat);
      do_req(1'b0, 3'b100, 32'h50, 32'd0, g_err, g_rd, g_lat, sel_cyc, wr_cyc, o_addr, o_width, o_wdata, waited);
      checks++;
      if (waited !== 1 || g_rd !== 32'h3C || g_lat !== 3) begin
         errors++;
         $display("FAIL held_request got waited %0d rdata %h lat %0d want 1 0000003c 3", waited, g_rd, g_lat);
      end
   endtask

   task automatic test_random;
      bit [2:0]  f3_pick [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
      bit        wr;
      bit [2:0]  f3;
      bit [31:0] addr, wd;
      for (int i = 0; i < 120; i++) begin
         wr   = ($urandom_range(0, 2) == 0);
         f3   = f3_pick[$urandom_range(0, 9)];
         addr = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 9) < 7) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
         if ($urandom_range(0, 11) == 0) addr = addr | ($urandom & 32'hFFFF_FC00) | 32'h400;
         wd = $urandom;
         model(wr, f3, addr, wd, e_err, e_width, e_wdata, e_rd, e_lat);
         do_req(wr, f3, addr, wd, g_err, g_rd, g_lat, sel_cyc, wr_cyc, o_addr, o_width, o_wdata, waited);
         checks++;
         if (g_err !== e_err || g_rd !== e_rd || g_lat !== e_lat) begin
            errors++;
            $display("FAIL rand_resp[%0d] wr %b f3 %0d addr %h got err %b rdata %h lat %0d want %b %h %0d",
                     i, wr, f3, addr, g_err, g_rd, g_lat, e_err, e_rd, e_lat);
         end
         checks++;
         if (e_err ? (sel_cyc !== 0)
                   : (sel_cyc !== 1 || wr_cyc !== int'(wr) || o_addr !== addr[9:0] ||
                      o_width !== e_width || (wr && o_wdata !== e_wdata))) begin
            errors++;
            $display("FAIL rand_bus[%0d] got sel %0d wr %0d addr %h width %b wdata %h want width %b wdata %h",
                     i, sel_cyc, wr_cyc, o_addr, o_width, o_wdata, e_width, e_wdata);
         end
      end
   endtask

   initial begin
      bit [31:0] w;
      checks = 0;
      errors = 0;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_funct3 = 3'd0;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;
      bus.mem_rdata  = 32'd0;
      for (int i = 0; i < 256; i++) begin
         w = $urandom;
         mem_words[i] = w;
         for (int j = 0; j < 4; j++) ref_mem[4*i + j] = w[8*j +: 8];
      end
      test_reset;
      test_reset_mid_load;
      test_store_load_word;
      test_sub_word;
      test_errors;
      test_back_to_back;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
